// File: rtl/seq_vedic_mul_8x8.sv
// Sequential 8x8 unsigned multiplier: one 4x4 Vedic multiplier reused over four
// cycles, accumulating nibble partial products into a 16-bit result.

module vedic_mul_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c1;

    assign c1   = a[1] & b[0] & a[0] & b[1];
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = a[1] & b[1] & c1;
endmodule

module vedic_mul_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;

    vedic_mul_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic_mul_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic_mul_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic_mul_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

    assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

module seq_vedic_mul_8x8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [1:0]  step;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  partial;
    logic [15:0] partial_shifted;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;

    // step[1] picks the multiplicand nibble, step[0] the multiplier nibble
    assign mul_a = step[1] ? a_q[7:4] : a_q[3:0];
    assign mul_b = step[0] ? b_q[7:4] : b_q[3:0];

    vedic_mul_4x4 u_mul (.a(mul_a), .b(mul_b), .p(partial));

    always_comb begin
        partial_shifted = {8'b0, partial};
        case (step)
            2'd1, 2'd2: partial_shifted = {4'b0, partial, 4'b0};
            2'd3:       partial_shifted = {partial, 8'b0};
            default:    partial_shifted = {8'b0, partial};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            step        <= 2'd0;
            acc         <= 16'h0000;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= multiplicand;
                        b_q        <= multiplier;
                        acc        <= 16'h0000;
                        step       <= 2'd0;
                        state      <= CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CALC: begin
                    acc  <= acc + partial_shifted;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    step        <= 2'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = acc;
endmodule

// File: tb/tb_seq_vedic_mul_8x8.sv
// Self-checking bench for seq_vedic_mul_8x8: directed corner cases plus random
// operands compared against a plain A*B reference with a 4-clock latency.

module tb_seq_vedic_mul_8x8;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seq_vedic_mul_8x8 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic scramble;
        in_valid     = 1'($urandom_range(0, 1));
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
    endtask

    // Waits for out_valid after the accept edge; returns number of edges taken.
    task automatic wait_result(input bit scr, output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            check("no_valid_in_calc", 32'(out_valid), 32'd0);
            check("in_ready_calc", 32'(in_ready), 32'd0);
            if (scr) begin
                scramble();
                out_ready = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold, input bit scr);
        logic [15:0] expv;
        int n;
        expv = 16'(a) * 16'(b);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        tick();
        check("busy_after_accept", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_result(scr, n);
        check("latency", 32'(n), 32'd4);
        check("result", 32'(result), 32'(expv));
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            if (scr) scramble();
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'(expv));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        if (scr) scramble();
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drop_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int c0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        multiplicand = 8'h00; multiplier = 8'h00;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);

        // idle without in_valid must not start
        tick(); tick();
        check("idle_no_start", 32'(busy), 32'd0);

        do_op(8'hFF, 8'hFF, 0, 1'b0);
        do_op(8'h00, 8'h5A, 0, 1'b0);
        do_op(8'h3C, 8'hA7, 10, 1'b0);

        // back-to-back with in_valid held high
        multiplicand = 8'h12; multiplier = 8'h34; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        c0 = cyc;
        multiplicand = 8'h0F; multiplier = 8'hF0;
        wait_result(1'b0, n);
        check("b2b_lat1", 32'(n), 32'd4);
        check("b2b_res1", 32'(result), 32'h03A8);
        tick();
        check("b2b_idle", 32'(in_ready), 32'd1);
        check("b2b_idle_valid", 32'(out_valid), 32'd0);
        tick();
        check("b2b_accept2", 32'(in_ready), 32'd0);
        check("b2b_interval", 32'(cyc - c0), 32'd6);
        in_valid = 1'b0;
        wait_result(1'b0, n);
        check("b2b_lat2", 32'(n), 32'd4);
        check("b2b_res2", 32'(result), 32'h0E10);
        tick();
        out_ready = 1'b0;
        check("b2b_done", 32'(in_ready), 32'd1);

        // reset during CALC step2 aborts the operation
        multiplicand = 8'hAB; multiplier = 8'hCD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        do_op(8'hAB, 8'hCD, 2, 1'b0);

        // reset while holding a result in DONE
        multiplicand = 8'h77; multiplier = 8'h99; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result(1'b0, n);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_done_valid", 32'(out_valid), 32'd0);
        check("abort_done_result", 32'(result), 32'd0);

        // random operands with input scrambling during the operation
        for (int k = 0; k < 40; k++) begin
            do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_vedic_mul_8x8.md
SEQ_VEDIC_MUL_8X8 -- requirements
Module: seq_vedic_mul_8x8

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 multiplicand  input  8  unsigned operand A.
REQ-007 multiplier  input  8  unsigned operand B.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 result  output  16  unsigned product A*B.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The block SHALL compute A*B with exactly one instance of the team's combinational 4x4 Vedic multiplier (8-bit product), reused over four cycles.
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; in CALC and DONE it SHALL be 0.
REQ-015 Accept = in_valid & in_ready at a rising edge; on accept: latch A and B, clear the 16-bit accumulator, set step counter to 0, go to CALC.
REQ-016 in_valid SHALL be ignored outside IDLE, and operand input changes after accept SHALL have no effect.
REQ-017 CALC step order, one per cycle, acc += product << shift: step0 A[3:0]*B[3:0] <<0; step1 A[3:0]*B[7:4] <<4; step2 A[7:4]*B[3:0] <<4; step3 A[7:4]*B[7:4] <<8.
REQ-018 Accumulation SHALL be 16-bit; no overflow is possible (max 0xFF*0xFF = 0xFE01) and no carry out is kept.
REQ-019 After step3 the FSM SHALL go to DONE; out_valid SHALL be 1 in the 4th cycle after the accept edge, i.e. latency = 4 clocks.
REQ-020 In DONE, result SHALL equal the accumulator and SHALL be held stable while out_ready is 0, for an unbounded number of cycles.
REQ-021 In DONE with out_ready=1 at a rising edge, the FSM SHALL return to IDLE and out_valid SHALL drop.
REQ-022 A new accept SHALL be possible no earlier than the cycle after IDLE is re-entered; minimum initiation interval = 6 clocks.
REQ-023 Outside DONE, out_valid SHALL be 0. result SHALL be driven by the accumulator at all times.
REQ-024 out_ready SHALL be ignored outside DONE.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL force state=IDLE, step=0, accumulator=0x0000 and latched operands=0.
REQ-026 In the cycle after reset, outputs SHALL be: in_ready=1, out_valid=0, busy=0, result=0x0000.
REQ-027 rst SHALL take priority over any handshake in the same cycle; a reset in CALC or DONE SHALL abort the operation without emitting a result.

Verification
REQ-028 Accept A=0xFF, B=0xFF, out_ready=1 -> out_valid rises 4 clocks after accept with result=0xFE01, then drops after one cycle.
REQ-029 A=0x12, B=0x34 followed immediately by A=0x0F, B=0xF0 with in_valid held high -> results 0x03A8 then 0x0E10; the second accept occurs exactly 6 clocks after the first.
REQ-030 A=0x00, B=0x5A -> result=0x0000 with the same 4-clock latency.
REQ-031 out_ready held 0 for 10 cycles in DONE -> out_valid=1, result constant, in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-032 rst pulsed during CALC step2 of 0xAB*0xCD -> next cycle in_ready=1, out_valid=0, result=0; a subsequent 0xAB*0xCD yields 0x88EF.
REQ-033 Toggle multiplicand, multiplier and in_valid randomly during CALC -> result still equals the product of the operands latched at accept.
